// File: rtl/div_unit_pkg.sv
// ============================================================================
// div_unit_pkg: shared RV64M divide opcodes, helpers and latency constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_unit_pkg;

  localparam int DIV_XLEN   = 64;
  localparam int DIV_LAT_64 = 66;
  localparam int DIV_LAT_32 = 34;

  typedef enum logic [2:0] {
    DIV   = 3'd0,
    DIVU  = 3'd1,
    REM   = 3'd2,
    REMU  = 3'd3,
    DIVW  = 3'd4,
    DIVUW = 3'd5,
    REMW  = 3'd6,
    REMUW = 3'd7
  } divfunc_t;

  function automatic logic is_word(input divfunc_t f);
    return f[2];
  endfunction

  function automatic logic is_signed(input divfunc_t f);
    return ~f[0];
  endfunction

  function automatic logic is_rem(input divfunc_t f);
    return f[1];
  endfunction

  function automatic logic [DIV_XLEN-1:0] word_sext(input logic [DIV_XLEN-1:0] x);
    return {{(DIV_XLEN-32){x[31]}}, x[31:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step: one combinational restoring radix-2 division iteration
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  // rem_i < divisor_i always holds, so the shifted partial remainder needs one extra bit
  assign w_shifted = {rem_i, quo_i[XLEN-1]};
  assign w_diff    = w_shifted - {1'b0, divisor_i};
  assign w_ge      = (w_shifted >= {1'b0, divisor_i});
  assign rem_o     = w_ge ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
  assign quo_o     = {quo_i[XLEN-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit: iterative RV64M divide/remainder unit with valid/ready handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      divfunc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] c
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_64 = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_32 = {{(XLEN-31){1'b1}}, 31'b0};

  logic [1:0]      state_q, state_d;
  logic [6:0]      cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, divisor_q, c_q;
  logic            qsign_q, rsign_q;
  divfunc_t        func_q;

  divfunc_t        w_func;
  logic            w_word, w_sgn, w_sa, w_sb, w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_a_adj, w_b_adj, w_mag_a, w_mag_b, w_spec_res;
  logic [XLEN-1:0] w_step_rem, w_step_quo, w_quo_fix, w_rem_fix, w_fix_res;

  // Width-adjust and take magnitudes of the incoming operands
  always_comb begin
    w_func  = divfunc_t'(divfunc);
    w_word  = is_word(w_func);
    w_sgn   = is_signed(w_func);
    w_a_adj = a;
    w_b_adj = b;
    if (w_word) begin
      w_a_adj = w_sgn ? word_sext(a) : {{(XLEN-32){1'b0}}, a[31:0]};
      w_b_adj = w_sgn ? word_sext(b) : {{(XLEN-32){1'b0}}, b[31:0]};
    end
    w_sa    = w_sgn & w_a_adj[XLEN-1];
    w_sb    = w_sgn & w_b_adj[XLEN-1];
    w_mag_a = w_sa ? -w_a_adj : w_a_adj;
    w_mag_b = w_sb ? -w_b_adj : w_b_adj;
    w_div0  = (w_b_adj == '0);
    w_ovf   = w_sgn && (w_a_adj == (w_word ? MIN_32 : MIN_64)) && (w_b_adj == '1);
    w_special = w_div0 | w_ovf;
    if (w_div0) begin
      w_spec_res = is_rem(w_func) ? w_a_adj : '1;
    end else begin
      w_spec_res = is_rem(w_func) ? '0 : w_a_adj;
    end
    if (w_word) begin
      w_spec_res = word_sext(w_spec_res);
    end
  end

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(divisor_q),
    .rem_o    (w_step_rem),
    .quo_o    (w_step_quo)
  );

  always_comb begin
    w_quo_fix = qsign_q ? -quo_q : quo_q;
    w_rem_fix = rsign_q ? -rem_q : rem_q;
    w_fix_res = is_rem(func_q) ? w_rem_fix : w_quo_fix;
    if (is_word(func_q)) begin
      w_fix_res = word_sext(w_fix_res);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) state_d = w_special ? S_DONE : S_CALC;
        S_CALC: if (cnt_q == 7'd1) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign c = c_q;

  // W ops pre-shift the dividend into the upper half so 32 steps leave the quotient in quo_q[31:0]
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      c_q       <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      func_q    <= DIV;
    end else if (!flush) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            func_q    <= w_func;
            qsign_q   <= w_sa ^ w_sb;
            rsign_q   <= w_sa;
            divisor_q <= w_mag_b;
            rem_q     <= '0;
            quo_q     <= w_word ? (w_mag_a << 32) : w_mag_a;
            cnt_q     <= w_word ? 7'd32 : 7'd64;
            if (w_special) begin
              c_q <= w_spec_res;
            end
          end
        end
        S_CALC: begin
          rem_q <= w_step_rem;
          quo_q <= w_step_quo;
          cnt_q <= cnt_q - 7'd1;
        end
        S_FIX: c_q <= w_fix_res;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit: self-checking bench for div_unit against an arithmetic model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  divfunc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] c;

  int n_cmp  = 0;
  int n_fail = 0;

  div_unit #(.XLEN(64)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .divfunc  (divfunc),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c        (c)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics computed directly with SV arithmetic
  task automatic ref_model(input logic [2:0] f, input logic [63:0] av, input logic [63:0] bv,
                           output logic [63:0] res, output int lat);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0] ua32, ub32, r32;
    bit word, rem, sgn, spec;
    word = (f == DIVW) || (f == DIVUW) || (f == REMW) || (f == REMUW);
    rem  = (f == REM)  || (f == REMU)  || (f == REMW) || (f == REMUW);
    sgn  = (f == DIV)  || (f == REM)   || (f == DIVW) || (f == REMW);
    spec = 1'b0;
    res  = '0;
    if (!word) begin
      sa = av;
      sb = bv;
      if (bv == 64'd0) begin
        spec = 1'b1;
        res  = rem ? av : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (sgn && av == 64'h8000_0000_0000_0000 && bv == 64'hFFFF_FFFF_FFFF_FFFF) begin
        spec = 1'b1;
        res  = rem ? 64'd0 : av;
      end else if (sgn) begin
        if (rem) res = sa % sb;
        else     res = sa / sb;
      end else begin
        if (rem) res = av % bv;
        else     res = av / bv;
      end
    end else begin
      ua32 = av[31:0];
      ub32 = bv[31:0];
      sa32 = av[31:0];
      sb32 = bv[31:0];
      r32  = '0;
      if (ub32 == 32'd0) begin
        spec = 1'b1;
        r32  = rem ? ua32 : 32'hFFFF_FFFF;
      end else if (sgn && ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) begin
        spec = 1'b1;
        r32  = rem ? 32'd0 : ua32;
      end else if (sgn) begin
        if (rem) r32 = sa32 % sb32;
        else     r32 = sa32 / sb32;
      end else begin
        if (rem) r32 = ua32 % ub32;
        else     r32 = ua32 / ub32;
      end
      res = {{32{r32[31]}}, r32};
    end
    lat = spec ? 1 : (word ? DIV_LAT_32 : DIV_LAT_64);
  endtask

  // Called one time unit after a rising edge while the unit is idle
  task automatic issue(input logic [2:0] f, input logic [63:0] av, input logic [63:0] bv);
    in_valid = 1'b1;
    divfunc  = f;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input string tag, input logic [63:0] exp_c, input int exp_lat,
                           input int hold);
    int cyc;
    cyc = 1;
    check({tag, " busy"}, {63'd0, in_ready}, 64'd0);
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " result"}, c, exp_c);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, " hold c"}, c, exp_c);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " idle after handshake"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] av,
                        input logic [63:0] bv, input int hold);
    logic [63:0] exp_c;
    int exp_lat;
    ref_model(f, av, bv, exp_c, exp_lat);
    issue(f, av, bv);
    finish_op(tag, exp_c, exp_lat, hold);
  endtask

  initial begin
    logic seen_valid;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    divfunc   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    check("reset in_ready/out_valid", {62'd0, in_ready, out_valid}, 64'd2);
    check("reset c", c, 64'd0);

    run_op("DIVU 100/7", DIVU, 64'd100, 64'd7, 0);
    run_op("REMU 100/7", REMU, 64'd100, 64'd7, 0);
    run_op("DIV -7/2", DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
    run_op("REM -7/2", REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
    run_op("DIVW ovf", DIVW, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
    run_op("REMW ovf", REMW, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
    run_op("DIVU by zero", DIVU, 64'd123, 64'd0, 0);
    run_op("REMU by zero", REMU, 64'd123, 64'd0, 0);
    run_op("DIV min/-1", DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("REMUW by zero", REMUW, 64'hDEAD_BEEF_9000_0001, 64'hFFFF_FFFF_0000_0000, 0);
    run_op("DIVUW big", DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd1, 0);

    // Flush in cycle 20 while a competing request is offered; flush must win
    issue(DIV, 64'h0123_4567_89AB_CDEF, 64'd12345);
    seen_valid = out_valid;
    repeat (19) begin
      @(posedge clk);
      #1;
      seen_valid |= out_valid;
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    divfunc  = DIVU;
    a        = 64'd50;
    b        = 64'd5;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush no out_valid", {63'd0, seen_valid}, 64'd0);
    check("flush idle cycle 21", {62'd0, in_ready, out_valid}, 64'd2);
    run_op("DIVU 9/3 after flush", DIVU, 64'd9, 64'd3, 0);

    run_op("DIVU stall", DIVU, 64'd1000, 64'd3, 5);

    // Reset during CALC abandons the operation and clears c
    issue(DIV, 64'd500, 64'd7);
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("mid reset in_ready/out_valid", {62'd0, in_ready, out_valid}, 64'd2);
    check("mid reset c", c, 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [63:0] av, bv;
      int          mode;
      f    = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 5);
      av   = {$urandom, $urandom};
      bv   = {$urandom, $urandom};
      case (mode)
        0: bv = {$urandom, 32'd0};
        1: begin
          bv = 64'hFFFF_FFFF_FFFF_FFFF;
          av = f[2] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        end
        2: begin
          bv = 64'($urandom_range(1, 15));
          if ($urandom_range(0, 1) == 1) bv = -bv;
        end
        3: av = 64'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op("random", f, av, bv, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
